// File: rtl/mire_writer.sv
// Wishbone master that paints a grid test pattern into the framebuffer, one word per pixel.
// Define MIRE_SCROLL_EN to repeat passes with a one-pixel horizontal scroll per pass.
module mire_writer #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int GRID  = 16,
    parameter int PAUSE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        busy,
    output logic        frame_done,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    input  logic        ack,
    input  logic [31:0] dat_sm
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int GW = $clog2(GRID);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, next;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [GW-1:0] off;
    logic          start;
    logic          adv;
    logic          x_last;
    logic          y_last;
    logic          pause_end;

    assign we  = 1'b1;
    assign sel = 4'b1111;
    assign cti = 3'b000;
    assign bte = 2'b00;
    assign stb = cyc;

    assign x_last = (x == XW'(HDISP - 1));
    assign y_last = (y == YW'(VDISP - 1));

    // The read side never looks at slave data; fold it away explicitly.
    logic unused_sig;
    assign unused_sig = ^{dat_sm, 32'(PAUSE)};

    // Address and pattern are pure functions of the counters so they stay put during a stall.
    logic [31:0] xe, ye;
    logic [GW-1:0] xg, yg;
    assign xe  = 32'(x);
    assign ye  = 32'(y);
    assign xg  = xe[GW-1:0] + off;
    assign yg  = ye[GW-1:0];
    assign adr = (32'(HDISP) * ye + xe) << 2;
    assign dat_ms = ((xg == '0) || (yg == '0)) ? 32'h00FF_FFFF : 32'h0000_0000;

`ifdef MIRE_SCROLL_EN
    localparam int PW = (PAUSE > 1) ? $clog2(PAUSE) : 1;
    logic [PW-1:0] pause_cnt;

    assign pause_end = (pause_cnt == PW'(PAUSE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pause_cnt <= '0;
            off       <= '0;
        end else begin
            if (frame_done) begin
                pause_cnt <= '0;
                off       <= off + 1'b1;
            end else if (state == S_PAUSE) begin
                pause_cnt <= pause_cnt + 1'b1;
            end
        end
    end
`else
    assign pause_end = 1'b0;
    assign off       = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next       = state;
        cyc        = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        start      = 1'b0;
        adv        = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    start = 1'b1;
                    next  = S_WRITE;
                end
            end
            S_WRITE: begin
                cyc  = 1'b1;
                busy = 1'b1;
                if (ack) begin
                    adv = 1'b1;
                    if (x_last && y_last) begin
                        frame_done = 1'b1;
`ifdef MIRE_SCROLL_EN
                        next = S_PAUSE;
`else
                        next = S_DONE;
`endif
                    end
                end
            end
`ifdef MIRE_SCROLL_EN
            S_PAUSE: begin
                busy = 1'b1;
                if (pause_end) begin
                    if (enable) begin
                        start = 1'b1;
                        next  = S_WRITE;
                    end else begin
                        next = S_IDLE;
                    end
                end
            end
`endif
            S_DONE: next = S_DONE;
            default: next = S_IDLE;
        endcase
    end

    // Raster counters: X fastest, wrapping both at the end of the frame.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mire_writer.sv
// Scoreboard bench for mire_writer: expected writes are queued per pass, a monitor checks every handshake.
module tb_mire_writer;

    localparam int HD = 32;
    localparam int VD = 4;
    localparam int GR = 16;
    localparam int PS = 8;
    localparam logic [31:0] WHITE = 32'h00FF_FFFF;

`ifdef MIRE_SCROLL_EN
    localparam int NPASS = 17;
`else
    localparam int NPASS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] dat_sm = 32'hDEAD_BEEF;
    logic        busy, frame_done, cyc, stb, we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] adr, dat_ms;

    mire_writer #(.HDISP(HD), .VDISP(VD), .GRID(GR), .PAUSE(PS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .busy(busy), .frame_done(frame_done),
        .cyc(cyc), .stb(stb), .we(we), .sel(sel), .cti(cti), .bte(bte),
        .adr(adr), .dat_ms(dat_ms), .ack(ack), .dat_sm(dat_sm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        fd;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int acks = 0;
    int fd_cnt = 0;
    int gap_checks = 0;
    int ack_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pass(input int off);
        exp_t e;
        for (int yy = 0; yy < VD; yy++) begin
            for (int xx = 0; xx < HD; xx++) begin
                e.adr = 32'(4 * (HD * yy + xx));
                e.dat = ((((xx + off) % GR) == 0) || ((yy % GR) == 0)) ? WHITE : 32'h0;
                e.fd  = (xx == HD - 1) && (yy == VD - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input int limit, output int ncyc);
        ncyc = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (cyc) ncyc++;
            if (q.size() == 0) break;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Slave model: 0 = never ack, 1 = ack every cycle, 2 = random 0..5 cycle stalls.
    initial begin : ackgen
        int stall;
        stall = 0;
        forever begin
            @(posedge clk); #2;
            case (ack_mode)
                0: ack = 1'b0;
                1: ack = 1'b1;
                default: begin
                    if (stall > 0) begin
                        ack = 1'b0;
                        stall--;
                    end else begin
                        ack = 1'b1;
                        stall = $urandom_range(5, 0);
                    end
                end
            endcase
        end
    end

    initial begin : monitor
        logic        pstall;
        logic [31:0] padr, pdat;
        logic        in_gap;
        int          gap;
        exp_t        e;
        pstall = 1'b0; padr = '0; pdat = '0; in_gap = 1'b0; gap = 0;
        forever begin
            @(negedge clk);
            if (pstall && !rst) begin
                chk1("stall_stb", stb, 1'b1);
                chk("stall_adr", adr, padr);
                chk("stall_dat", dat_ms, pdat);
            end
            if (in_gap) begin
                if (!busy) in_gap = 1'b0;
                else if (cyc) begin
                    chk("pause_len", gap, PS);
                    gap_checks++;
                    in_gap = 1'b0;
                end else gap++;
            end
            if (cyc && stb && ack) begin
                acks++;
                chk1("write_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("adr", adr, e.adr);
                    chk("dat_ms", dat_ms, e.dat);
                    chk1("frame_done", frame_done, e.fd);
                end
                if (frame_done) begin
                    fd_cnt++;
                    in_gap = 1'b1;
                    gap = 0;
                end
            end else if (frame_done) begin
                chk1("fd_without_ack", frame_done, 1'b0);
            end
            pstall = cyc && stb && !ack;
            padr = adr;
            pdat = dat_ms;
        end
    end

    initial begin : main
        int ncyc;
        int tgt;
        rst = 1'b1; enable = 1'b0; ack_mode = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Idle after reset, enable low
        repeat (4) begin
            @(negedge clk); #1;
            chk1("rst_cyc", cyc, 1'b0);
            chk1("rst_stb", stb, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_fd", frame_done, 1'b0);
            chk("rst_adr", adr, 32'h0);
            chk("rst_dat", dat_ms, WHITE);
        end
        chk1("we", we, 1'b1);
        chk("sel", 32'(sel), 32'hF);
        chk("cti", 32'(cti), 32'h0);
        chk("bte", 32'(bte), 32'h0);

        // Full-speed pass(es), ack tied high
        ack_mode = 1;
        for (int k = 0; k < NPASS; k++) push_pass(k % GR);
        @(posedge clk); #2 enable = 1'b1;
        wait_drain(6000, ncyc);
        chk("write_cycles", ncyc, 128 * NPASS);
        enable = 1'b0;
`ifdef MIRE_SCROLL_EN
        repeat (12) @(negedge clk);
        #1;
        chk1("end_idle_cyc", cyc, 1'b0);
        chk1("end_idle_busy", busy, 1'b0);
        chk("pause_gaps", gap_checks, NPASS - 1);
`else
        repeat (3) begin
            @(posedge clk); #2 enable = 1'b1;
            @(negedge clk); #1;
            chk1("done_cyc", cyc, 1'b0);
            chk1("done_busy", busy, 1'b0);
            @(posedge clk); #2 enable = 1'b0;
            @(negedge clk); #1;
            chk1("done_cyc", cyc, 1'b0);
            chk1("done_busy", busy, 1'b0);
        end
`endif
        chk("frame_count", fd_cnt, NPASS);

        // Reset sampled together with the 50th ack
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        push_pass(0);
        tgt = acks + 50;
        @(posedge clk); #2 enable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (acks >= tgt) break;
        end
        chk("ack50_reached", acks, tgt);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk); #1;
        chk1("midrst_cyc", cyc, 1'b0);
        chk1("midrst_stb", stb, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk("midrst_adr", adr, 32'h0);
        chk("midrst_dat", dat_ms, WHITE);
        q.delete();
        @(posedge clk); #2 rst = 1'b0;

        // Restart from adr 0 with random stalls; enable dropped mid-pass
        ack_mode = 2;
        push_pass(0);
        @(posedge clk); #2 enable = 1'b1;
        @(negedge clk); #1;
        chk1("start_lat_idle", cyc, 1'b0);
        @(negedge clk); #1;
        chk1("start_lat_cyc", cyc, 1'b1);
        chk("restart_adr", adr, 32'h0);
        chk("restart_dat", dat_ms, WHITE);
        enable = 1'b0;
        wait_drain(3000, ncyc);
        repeat (20) @(negedge clk);
        #1;
        chk1("final_cyc", cyc, 1'b0);
        chk1("final_busy", busy, 1'b0);
        chk("frame_count_final", fd_cnt, NPASS + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mire_writer.md
# mire_writer

Wishbone master that fills the SDRAM framebuffer with a grid test pattern, one 32-bit word per pixel, at the same addresses the VGA read stage fetches (4*(HDISP*Y+X)). It sits upstream of the VGA stage on the system bus, as the second master port of the bus arbiter, and runs entirely in the Wishbone clock domain. Optionally the pattern scrolls horizontally by one pixel per completed pass, which gives a visible end-to-end test of the write → SDRAM → FIFO → display path.

## Interface
- HDISP, 800: pixels per line; must equal the VGA stage's HDISP.
- VDISP, 480: lines per frame; must equal the VGA stage's VDISP.
- GRID, 16: grid pitch in pixels; power of 2, 2..HDISP.
- PAUSE, 1024: idle cycles between passes, ≥1.

Ports:
- wshb_ifm.clk  input  1  Wishbone clock, the only clock.
- wshb_ifm.rst  input  1  reset: synchronous, active-high.
- enable  input  1  level; 1 allows a new pass to start.
- busy  output  1  1 in WRITE or PAUSE.
- frame_done  output  1  one-cycle pulse on the cycle the last pixel's ack is sampled.
- wshb_ifm.cyc / wshb_ifm.stb  output  1  bus request; both equal 1 exactly in WRITE.
- wshb_ifm.we  output  1  constant 1.
- wshb_ifm.sel  output  4  constant 4'b1111.
- wshb_ifm.cti  output  3  constant 3'b000 (classic cycle).
- wshb_ifm.bte  output  2  constant 0.
- wshb_ifm.adr  output  32  4*(HDISP*Y+X).
- wshb_ifm.dat_ms  output  32  pattern word for (X,Y).
- wshb_ifm.ack  input  1  slave acknowledge.
- wshb_ifm.dat_sm  input  32  ignored.

## Operation
- Counters: X (0..HDISP-1), Y (0..VDISP-1), sized with $clog2; off (0..GRID-1); pause counter.
- Pattern:
  - 32'h00FFFFFF when ((X+off) mod GRID)==0 or (Y mod GRID)==0.
  - Otherwise 32'h00000000.
  - mod uses the low $clog2(GRID) bits.
- FSM states: IDLE, WRITE, PAUSE, DONE.
- IDLE: cyc=stb=0. If enable=1, clear X and Y and go to WRITE.
- WRITE: cyc=stb=1; adr/dat_ms are combinational from X, Y, off.
  - On each ack: X increments.
  - When X==HDISP-1: X→0 and Y increments.
  - When X==HDISP-1 and Y==VDISP-1 (last pixel):
    - X and Y both go to 0.
    - frame_done=1.
    - The pause counter clears.
    - The FSM goes to PAUSE (with MIRE_SCROLL_EN) or DONE (without).
  - With no ack, all registers hold; stb stays asserted and adr/dat_ms stay stable.
- PAUSE: cyc=stb=0 for exactly PAUSE cycles. The next state is then WRITE if enable=1, else IDLE.
- DONE: terminal; cyc=stb=0, busy=0, enable ignored until reset.
- enable deasserting mid-pass does not abort the pass; it only affects the decision at the end of PAUSE.
- Reset values: state=IDLE, X=Y=off=0, cyc=stb=busy=frame_done=0, adr=0, dat_ms=32'h00FFFFFF (pixel (0,0) lies on the grid).

## Timing
- enable sampled 1 in IDLE → cyc=stb=1 from the next cycle.
- Back-to-back acks are supported. Every cycle with ack=1 completes one word, and the next address is presented the following cycle without dropping stb.
- Best-case pass length: HDISP*VDISP cycles.
- Reset sampled mid-pass: on the next edge cyc=stb=0 and all registers take their reset values; the partial frame is not resumed.
- adr width rule: 4*(HDISP*VDISP-1) must fit in 32 bits. The product is computed in 32-bit arithmetic.

## Configuration
- MIRE_SCROLL_EN defined:
  - After each pass, off ← (off+1) mod GRID on the frame_done cycle.
  - The FSM goes to PAUSE, then repeats passes while enable=1.
- MIRE_SCROLL_EN undefined:
  - off is fixed at 0 and the PAUSE state is not built.
  - After one pass the FSM enters DONE and issues no further bus cycles until reset.

## Test plan
Parameters for all scenarios: HDISP=32, VDISP=4, GRID=16, PAUSE=8.
- Reset, enable=0 → cyc=stb=busy=0; adr=0; dat_ms=32'h00FFFFFF held indefinitely.
- enable=1, ack tied 1 → 128 consecutive writes.
  - adr runs 0,4,…,508.
  - dat_ms is white at X∈{0,16} and on line Y=0, black elsewhere.
  - frame_done pulses exactly once, on the ack of adr=508.
- Random ack stalls (ack held 0 for 0–5 cycles) → adr/dat_ms/stb stable during each stall; the written sequence is identical to the no-stall run.
- With MIRE_SCROLL_EN, enable held 1 → exactly 8 idle cycles between passes.
  - Pass 2 is white at X∈{15,31}.
  - The pass-17 pattern equals pass 1.
- Without MIRE_SCROLL_EN → after 128 acks, cyc=0 and busy=0 permanently; toggling enable issues no new cycle.
- Reset asserted at the 50th ack → cyc=0 on the next edge. A subsequent enable restarts at adr=0, off=0.
